bank_response_arbiter: RTL and testbench
========================================

# bank_response_arbiter

Merges the per-bank response queues of one rank into a single response channel toward the rank/channel controller. Grants round-robin across banks with a starvation override and presents the winner through a one-entry registered output stage. It sits between the bank response queues and the controller's response port.

## Interface
- NUM_BANKS, 8, number of bank response queues arbitrated (≥2)
- ADDR_W, 32, response address width
- DATA_W, 32, response data width
- ID_W, 32, request ID width
- WAIT_W, 8, width of per-bank wait counters
- STARVE_LIMIT, 16, wait count at which a bank is forced to win (< 2^WAIT_W)
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- bank_resp_valid  input  NUM_BANKS  per-bank response valid
- bank_resp_ready  output  NUM_BANKS  per-bank accept, one-hot or zero
- bank_resp_addr  input  NUM_BANKS*ADDR_W  per-bank address, bank i at slice i
- bank_resp_data  input  NUM_BANKS*DATA_W  per-bank data
- bank_resp_id  input  NUM_BANKS*ID_W  per-bank request ID
- out_valid  output  1  merged response valid
- out_ready  input  1  downstream accept
- out_addr / out_data / out_id  output  ADDR_W / DATA_W / ID_W  merged payload
- out_bank  output  $clog2(NUM_BANKS)  source bank index of the presented response

## Operation
- Slot free when `!out_valid || out_ready`. Arbitration runs only when the slot is free; otherwise `bank_resp_ready` is all zero.
- Winner selection:
  - If any valid bank has `wait_cnt >= STARVE_LIMIT`, the lowest-index such bank wins.
  - Otherwise the first valid bank at or after `rr_ptr`, searching upward and wrapping, wins.
- A grant to bank g does all of the following:
  - `bank_resp_ready[g]=1` in the same cycle. The ready is combinational from valid; sources must not make valid depend on ready.
  - Payload and g load into the output register at the clock edge.
  - `rr_ptr <= (g+1) mod NUM_BANKS`, including for starvation grants.
  - `wait_cnt[g] <= 0`.
- Wait counters:
  - A bank that is valid but not granted increments its counter, saturating at 2^WAIT_W−1.
  - A bank that is not valid clears its counter.
  - While the slot is blocked, every valid bank increments.
- Output register:
  - Loads when a grant occurs.
  - Clears `out_valid` on `out_ready` with no new grant.
  - Holds its payload stable while `out_valid && !out_ready`.
- No grants while reset is high. The response stream must not drop or duplicate any response.

## Timing
- Latency: bank accepted at edge N → `out_valid=1` with its payload from cycle N+1.
- Throughput: one response per cycle when `out_ready` is held high.
- Reset values: `out_valid=0`; `out_addr/out_data/out_id/out_bank=0`; `rr_ptr=0`; all `wait_cnt=0`; `bank_resp_ready=0` while reset is asserted.
- Reset mid-operation: any held response is discarded; the first grant happens in the cycle after reset deasserts.
- Simultaneous `out_ready` and grant: the held entry leaves and the new one loads at the same edge, so `out_valid` stays 1.

## Configuration
- `BANK_RESP_ARB_STATS_EN` defined: adds these outputs, both reset to 0 and wrapping at 2^32:
  - `stat_grants` (32 bits): +1 per grant.
  - `stat_starve_grants` (32 bits): +1 per grant made by the starvation override.
- `BANK_RESP_ARB_STATS_EN` undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Package `bank_resp_arb_pkg` holds:
  - `bank_resp_t` struct {addr, data, id}.
  - A bank-index typedef.
  - Default-width localparams.
- Sub-module `rr_priority_picker`: combinational. Inputs are a request vector and a start pointer; outputs are a one-hot grant and an index. It is used twice: once for round-robin, and once with pointer 0 for the starved-bank search.
- Top level holds the output register, `rr_ptr`, the wait counters and the optional stats.

## Test plan
- Single bank: bank 3 valid with id=0x11, `out_ready=1` → `bank_resp_ready=0b00001000` in cycle 0; `out_valid`, `out_id=0x11`, `out_bank=3` in cycle 1.
- Round-robin: all 8 banks valid continuously, `out_ready=1` → `out_bank` sequence 0,1,…,7,0 with no bubbles.
- Backpressure: `out_ready=0` for 5 cycles with banks 1 and 2 valid → payload held stable, no readies asserted; after release, the held response then bank 1 are delivered, with no loss or duplication.
- Starvation: STARVE_LIMIT=4, `out_ready=0` for 6 cycles with bank 5 valid, then banks 0 and 5 valid with `rr_ptr=0` → bank 5 wins and `stat_starve_grants=1` (stats build).
- Reset mid-stream: assert reset while `out_valid=1` → next cycle all outputs 0, `rr_ptr=0`; after deassert, bank 0 wins first.
- Simultaneous drain/load: held entry from bank 2, `out_ready=1`, bank 4 valid → `out_valid` stays 1, `out_bank` 2→4 in consecutive cycles.

Source files
------------

// File: rtl/bank_resp_arb_pkg.sv
// bank_resp_arb_pkg
//   Shared types and default widths for the bank response arbiter.
//   bank_resp_t  : one response payload {addr, data, id} at default widths
//   bank_idx_t   : bank index at the default bank count
//   wrap_inc     : increment an index modulo a count (round-robin pointer step)
package bank_resp_arb_pkg;

    localparam int DEF_NUM_BANKS    = 8;
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_ID_W         = 32;
    localparam int DEF_WAIT_W       = 8;
    localparam int DEF_STARVE_LIMIT = 16;
    localparam int DEF_IDX_W        = $clog2(DEF_NUM_BANKS);

    typedef logic [DEF_IDX_W-1:0] bank_idx_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ID_W-1:0]   id;
    } bank_resp_t;

    function automatic int wrap_inc(input int idx, input int count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bank_response_arbiter_rr_priority_picker.sv
// rr_priority_picker
//   Combinational rotating-priority picker. Finds the first set bit of req at
//   or above start, wrapping to bit 0 when nothing is set above start.
//   Ports:
//     req   in  [N-1:0]      request vector
//     start in  [IDX_W-1:0]  highest-priority position
//     grant out [N-1:0]      one-hot grant (zero when found=0)
//     idx   out [IDX_W-1:0]  index of the granted bit (zero when found=0)
//     found out              any request set
module rr_priority_picker
    import bank_resp_arb_pkg::*;
#(
    parameter int N     = DEF_NUM_BANKS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic             lo_found;
    logic [IDX_W-1:0] lo_idx;

    // Two descending scans: the last hit written is the lowest index. The
    // "hi" scan only considers positions >= start, the "lo" scan everything,
    // which covers the wrapped part of the search.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                if (IDX_W'(i) >= start) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        found = lo_found;
        idx   = '0;
        grant = '0;
        if (hi_found) begin
            idx = hi_idx;
        end else if (lo_found) begin
            idx = lo_idx;
        end
        if (found) begin
            grant = N'(1) << idx;
        end
    end

endmodule

// File: rtl/bank_response_arbiter.sv
// bank_response_arbiter
//   Merges per-bank response queues of one rank into a single registered
//   response channel. Round-robin arbitration with a starvation override:
//   any valid bank whose wait count reached STARVE_LIMIT wins, lowest index
//   first. The winner is presented through a one-entry output register.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     bank_resp_valid   in  [NUM_BANKS]          per-bank response valid
//     bank_resp_ready   out [NUM_BANKS]          per-bank accept (one-hot/zero),
//                                                combinational from valid
//     bank_resp_addr    in  [NUM_BANKS*ADDR_W]   bank i at slice i
//     bank_resp_data    in  [NUM_BANKS*DATA_W]
//     bank_resp_id      in  [NUM_BANKS*ID_W]
//     out_valid/ready   merged response handshake
//     out_addr/data/id  merged payload
//     out_bank          source bank of the presented response
//
//   Optional build macro BANK_RESP_ARB_STATS_EN adds:
//     stat_grants         out [32]  grants made (wrapping)
//     stat_starve_grants  out [32]  grants made by the starvation override
module bank_response_arbiter
    import bank_resp_arb_pkg::*;
#(
    parameter int NUM_BANKS    = DEF_NUM_BANKS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ID_W         = DEF_ID_W,
    parameter int WAIT_W       = DEF_WAIT_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BANKS-1:0]          bank_resp_valid,
    output logic [NUM_BANKS-1:0]          bank_resp_ready,
    input  logic [NUM_BANKS*ADDR_W-1:0]   bank_resp_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_resp_data,
    input  logic [NUM_BANKS*ID_W-1:0]     bank_resp_id,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [DATA_W-1:0]             out_data,
    output logic [ID_W-1:0]               out_id,
    output logic [$clog2(NUM_BANKS)-1:0]  out_bank
`ifdef BANK_RESP_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_grants,
    output logic [31:0]                   stat_starve_grants
`endif
);

    localparam int IDX_W = $clog2(NUM_BANKS);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);

    // Parameter-width mirror of bank_resp_t so non-default widths still work.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
    } resp_t;

    logic [IDX_W-1:0]     rr_ptr;
    logic [WAIT_W-1:0]    wait_cnt [NUM_BANKS];
    logic [NUM_BANKS-1:0] starved;

    logic [NUM_BANKS-1:0] rr_grant;
    logic [IDX_W-1:0]     rr_idx;
    logic                 rr_found;
    logic [NUM_BANKS-1:0] st_grant;
    logic [IDX_W-1:0]     st_idx;
    logic                 st_found;

    logic [NUM_BANKS-1:0] win_grant;
    logic [IDX_W-1:0]     win_idx;
    logic                 slot_free;
    logic                 grant_fire;
    resp_t                win_resp;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            starved[i] = bank_resp_valid[i] && (wait_cnt[i] >= STARVE_TH);
        end
    end

    rr_priority_picker #(
        .N     (NUM_BANKS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (bank_resp_valid),
        .start (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    rr_priority_picker #(
        .N     (NUM_BANKS),
        .IDX_W (IDX_W)
    ) u_starve_pick (
        .req   (starved),
        .start ('0),
        .grant (st_grant),
        .idx   (st_idx),
        .found (st_found)
    );

    // rr_found is simply "any bank valid", so it gates both grant sources.
    assign win_grant  = st_found ? st_grant : rr_grant;
    assign win_idx    = st_found ? st_idx   : rr_idx;
    assign slot_free  = !out_valid || out_ready;
    assign grant_fire = !reset && slot_free && rr_found;

    assign bank_resp_ready = grant_fire ? win_grant : '0;

    always_comb begin
        win_resp = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (win_grant[i]) begin
                win_resp.addr = bank_resp_addr[i*ADDR_W +: ADDR_W];
                win_resp.data = bank_resp_data[i*DATA_W +: DATA_W];
                win_resp.id   = bank_resp_id[i*ID_W +: ID_W];
            end
        end
    end

    // Output register and round-robin pointer. A grant takes priority over a
    // plain drain, so a drain and a load at the same edge keep out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_id    <= '0;
            out_bank  <= '0;
            rr_ptr    <= '0;
        end else if (grant_fire) begin
            out_valid <= 1'b1;
            out_addr  <= win_resp.addr;
            out_data  <= win_resp.data;
            out_id    <= win_resp.id;
            out_bank  <= win_idx;
            rr_ptr    <= IDX_W'(wrap_inc(int'(win_idx), NUM_BANKS));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Wait counters: cleared when idle or granted, otherwise count up and
    // saturate. A blocked slot yields no grant, so every valid bank counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (reset) begin
                wait_cnt[i] <= '0;
            end else if (!bank_resp_valid[i] || bank_resp_ready[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != WAIT_MAX) begin
                wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
            end
        end
    end

`ifdef BANK_RESP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants        <= '0;
            stat_starve_grants <= '0;
        end else if (grant_fire) begin
            stat_grants <= stat_grants + 32'd1;
            if (st_found) begin
                stat_starve_grants <= stat_starve_grants + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bank_response_arbiter.sv
// tb_bank_response_arbiter
//   Directed bench for bank_response_arbiter at default parameters
//   (8 banks, STARVE_LIMIT 16). Default payload for bank b:
//   addr A000_000b, data D000_000b, id 0x10+b.
module tb_bank_response_arbiter;

    localparam int NB = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [NB-1:0]      bank_resp_valid;
    logic [NB-1:0]      bank_resp_ready;
    logic [NB*AW-1:0]   bank_resp_addr;
    logic [NB*DW-1:0]   bank_resp_data;
    logic [NB*IW-1:0]   bank_resp_id;
    logic               out_valid;
    logic               out_ready;
    logic [AW-1:0]      out_addr;
    logic [DW-1:0]      out_data;
    logic [IW-1:0]      out_id;
    logic [2:0]         out_bank;
`ifdef BANK_RESP_ARB_STATS_EN
    logic [31:0]        stat_grants;
    logic [31:0]        stat_starve_grants;
    logic [31:0]        grants_before;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bank_response_arbiter #(
        .NUM_BANKS    (NB),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .ID_W         (IW),
        .WAIT_W       (8),
        .STARVE_LIMIT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bank_resp_valid (bank_resp_valid),
        .bank_resp_ready (bank_resp_ready),
        .bank_resp_addr  (bank_resp_addr),
        .bank_resp_data  (bank_resp_data),
        .bank_resp_id    (bank_resp_id),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .out_id          (out_id),
        .out_bank        (out_bank)
`ifdef BANK_RESP_ARB_STATS_EN
        ,
        .stat_grants        (stat_grants),
        .stat_starve_grants (stat_starve_grants)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_bank(input int b, input logic [31:0] id);
        bank_resp_addr[b*AW +: AW] = 32'hA000_0000 + 32'(b);
        bank_resp_data[b*DW +: DW] = 32'hD000_0000 + 32'(b);
        bank_resp_id[b*IW +: IW]   = id;
    endtask

    task automatic check_out(input string tag, input int b, input logic [31:0] id);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_bank"},  64'(out_bank),  64'(b));
        check({tag, "_id"},    64'(out_id),    64'(id));
        check({tag, "_addr"},  64'(out_addr),  64'(32'hA000_0000 + 32'(b)));
        check({tag, "_data"},  64'(out_data),  64'(32'hD000_0000 + 32'(b)));
    endtask

    // Primes rr_ptr to 0 via a bank 7 grant, blocks the slot for n cycles
    // with bank 5 valid, then offers banks 0 and 5 with the slot free.
    task automatic starve_phase(input string tag, input int n, input int exp_bank);
        logic [7:0] exp_ready;
        exp_ready = 8'b1 << exp_bank;
        out_ready = 1'b0;
        bank_resp_valid = 8'h80;
        step();
        check_out({tag, "_prime"}, 7, 32'h17);
        bank_resp_valid = 8'h20;
        repeat (n) step();
        check({tag, "_blocked_bank"}, 64'(out_bank), 64'd7);
        bank_resp_valid = 8'h21;
        out_ready = 1'b1;
        settle();
        check({tag, "_ready"}, 64'(bank_resp_ready), 64'(exp_ready));
        step();
        check_out({tag, "_win"}, exp_bank, 32'h10 + 32'(exp_bank));
        bank_resp_valid = 8'h00;
        step();
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [7:0] exp_ready;

        reset = 1'b1;
        out_ready = 1'b0;
        bank_resp_valid = 8'hFF;
        for (int b = 0; b < NB; b++) set_bank(b, 32'h10 + 32'(b));
        step();
        step();

        // Reset state
        check("rst_ready", 64'(bank_resp_ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_bank",  64'(out_bank),  64'd0);
        check("rst_id",    64'(out_id),    64'd0);
        check("rst_addr",  64'(out_addr),  64'd0);
        check("rst_data",  64'(out_data),  64'd0);

        // Single bank: bank 3 with id 0x11
        reset = 1'b0;
        bank_resp_valid = 8'h08;
        set_bank(3, 32'h11);
        out_ready = 1'b1;
        settle();
        check("single_ready", 64'(bank_resp_ready), 64'h08);
        step();
        check_out("single", 3, 32'h11);
        bank_resp_valid = 8'h00;
        set_bank(3, 32'h13);
        step();
        check("single_drain", 64'(out_valid), 64'd0);

        // Round-robin from rr_ptr=0 with all banks valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        bank_resp_valid = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_ready = 8'b1 << (k % 8);
            settle();
            check("rr_ready", 64'(bank_resp_ready), 64'(exp_ready));
            step();
            check_out("rr", k % 8, 32'h10 + 32'(k % 8));
        end
        bank_resp_valid = 8'h00;
        step();
        check("rr_drain", 64'(out_valid), 64'd0);

        // Backpressure: rr_ptr=1, banks 1 and 2 valid
        bank_resp_valid = 8'h06;
        out_ready = 1'b0;
        settle();
        check("bp_first_ready", 64'(bank_resp_ready), 64'h02);
        step();
        check_out("bp_load", 1, 32'h11);
        set_bank(1, 32'h21);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("bp_hold_ready", 64'(bank_resp_ready), 64'd0);
            step();
            check_out("bp_hold", 1, 32'h11);
        end
        out_ready = 1'b1;
        settle();
        check("bp_rel_ready", 64'(bank_resp_ready), 64'h04);
        step();
        check_out("bp_b2", 2, 32'h12);
        bank_resp_valid = 8'h02;
        settle();
        check("bp_b1_ready", 64'(bank_resp_ready), 64'h02);
        step();
        check_out("bp_b1", 1, 32'h21);
        bank_resp_valid = 8'h00;
        set_bank(1, 32'h11);
        step();
        check("bp_drain", 64'(out_valid), 64'd0);

        // Simultaneous drain/load: held bank 2, then bank 4
        bank_resp_valid = 8'h04;
        out_ready = 1'b0;
        step();
        check_out("sim_held", 2, 32'h12);
        bank_resp_valid = 8'h10;
        settle();
        check("sim_block_ready", 64'(bank_resp_ready), 64'd0);
        step();
        check_out("sim_still", 2, 32'h12);
        out_ready = 1'b1;
        settle();
        check("sim_ready", 64'(bank_resp_ready), 64'h10);
        step();
        check_out("sim_new", 4, 32'h14);
        bank_resp_valid = 8'h00;
        step();
        check("sim_drain", 64'(out_valid), 64'd0);

        // Starvation boundary: 15 waits is below the limit, 16 reaches it
        starve_phase("starve15", 15, 0);
`ifdef BANK_RESP_ARB_STATS_EN
        grants_before = stat_grants;
`endif
        starve_phase("starve16", 16, 5);
`ifdef BANK_RESP_ARB_STATS_EN
        check("stat_starve", 64'(stat_starve_grants), 64'd1);
        check("stat_grants_delta", 64'(stat_grants - grants_before), 64'd2);
`endif

        // Reset mid-stream while a response is held
        out_ready = 1'b0;
        bank_resp_valid = 8'h08;
        step();
        check_out("mid_held", 3, 32'h13);
        reset = 1'b1;
        bank_resp_valid = 8'hFF;
        settle();
        check("mid_rst_ready", 64'(bank_resp_ready), 64'd0);
        step();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_bank",  64'(out_bank),  64'd0);
        check("mid_rst_id",    64'(out_id),    64'd0);
        check("mid_rst_addr",  64'(out_addr),  64'd0);
        check("mid_rst_data",  64'(out_data),  64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        settle();
        check("mid_first_ready", 64'(bank_resp_ready), 64'h01);
        step();
        check_out("mid_first", 0, 32'h10);
        bank_resp_valid = 8'h00;
        step();
        check("mid_drain", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
